// File: rtl/fifo_burst_reader_if.sv
// Signal bundle between fifo_burst_reader, its upstream fifo read port and
// its downstream valid/ready consumer. master = the reader, slave = its environment.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a 1-cycle-latency fifo into a 2-entry skid buffer and a burst-framed stream.
// Optional beat/burst statistics counters: define FIFO_BURST_READER_STATS_EN.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int BCNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FIFO_BURST_READER_STATS_EN
    output logic [31:0]         stat_beats,
    output logic [15:0]         stat_bursts,
`endif
    fifo_burst_reader_if.master bus
);

    logic [1:0]            r_stored;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [BCNT_W-1:0]     r_bcnt;

    logic                  w_pop;
    logic                  w_last;
    logic [2:0]            w_occupancy;

    assign w_pop       = bus.m_valid && bus.m_ready;
    assign w_occupancy = {1'b0, r_stored} + {2'b00, r_inflight};

    // A beat leaving this cycle frees a slot, so it counts as room for the next pop.
    assign bus.fifo_rd_en = !rst && !bus.fifo_empty
                            && (w_occupancy < (3'd2 + {2'b00, w_pop}));

    assign w_last      = (r_bcnt == BCNT_W'(BURST_LEN - 1));
    assign bus.m_valid = (r_stored != 2'd0);
    assign bus.m_data  = r_head;
    assign bus.m_last  = bus.m_valid && w_last;

    // NOTE: the data words are reset as well so m_data reads 0 while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stored   <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            r_inflight <= bus.fifo_rd_en;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_stored == 2'd0) r_head <= bus.fifo_rd_data;
                    else                  r_tail <= bus.fifo_rd_data;
                    r_stored <= r_stored + 2'd1;
                end
                2'b01: begin
                    r_head   <= r_tail;
                    r_stored <= r_stored - 2'd1;
                end
                2'b11: begin
                    if (r_stored == 2'd1) begin
                        r_head <= bus.fifo_rd_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= bus.fifo_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat position within the current burst; holds across fifo-empty gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt <= '0;
        end else if (w_pop) begin
            r_bcnt <= w_last ? '0 : r_bcnt + 1'b1;
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    logic [31:0] r_stat_beats;
    logic [15:0] r_stat_bursts;

    // Both counters wrap naturally at their full width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_beats  <= '0;
            r_stat_bursts <= '0;
        end else if (w_pop) begin
            r_stat_beats <= r_stat_beats + 32'd1;
            if (bus.m_last) r_stat_bursts <= r_stat_bursts + 16'd1;
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_bursts = r_stat_bursts;
`else
    // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-based upstream fifo model,
// an expected-beat log filled at push time, and a negedge monitor that consumes it.
module tb_fifo_burst_reader;
    localparam int DW  = 32;
    localparam int BL  = 4;
    localparam int BCW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_BURST_READER_STATS_EN
    logic [31:0] stat_beats;
    logic [15:0] stat_bursts;
`endif

    fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .BCNT_W(BCW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FIFO_BURST_READER_STATS_EN
        .stat_beats(stat_beats),
        .stat_bursts(stat_bursts),
`endif
        .bus(bus)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] fifo_q[$];
    beat_t         push_log[$];
    int            reset_base = 0;
    int            n_pushed   = 0;
    int            n_popped   = 0;
    int            exp_idx    = 0;
    int            n_accepted = 0;
    int            n_bursts   = 0;
    logic          rd_sample  = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, consumes the expected-beat log in order.
    always @(negedge clk) begin
        rd_sample = bus.fifo_rd_en;
        if (rst) begin
            exp_idx    = reset_base;
            n_accepted = 0;
            n_bursts   = 0;
            stall_prev = 1'b0;
        end else begin
            check("rd_en_while_empty", 64'(bus.fifo_rd_en && bus.fifo_empty), 64'd0);
            check("occupancy_le_2", 64'((n_popped - n_accepted) <= 2), 64'd1);
            if (stall_prev) begin
                check("stall_valid_held", 64'(bus.m_valid), 64'd1);
                check("stall_data_held", 64'(bus.m_data), 64'(held_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                check("beat_expected", 64'(exp_idx < push_log.size()), 64'd1);
                if (exp_idx < push_log.size()) begin
                    check("beat_data", 64'(bus.m_data), 64'(push_log[exp_idx].data));
                    check("beat_last", 64'(bus.m_last), 64'(push_log[exp_idx].last));
                    if (push_log[exp_idx].last) n_bursts++;
                    exp_idx++;
                end
                n_accepted++;
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            held_data  = bus.m_data;
        end
    end

    // One clock; the upstream fifo model answers a pop one cycle later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_sample && !rst) begin
            check("pop_nonempty", 64'(fifo_q.size() != 0), 64'd1);
            if (fifo_q.size() != 0) bus.fifo_rd_data = fifo_q.pop_front();
            n_popped++;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        beat_t b;
        b.data = w;
        b.last = ((n_pushed % BL) == (BL - 1));
        push_log.push_back(b);
        fifo_q.push_back(w);
        n_pushed++;
        bus.fifo_empty = 1'b0;
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        #1;
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_data", 64'(bus.m_data), 64'd0);
        check("rst_m_last", 64'(bus.m_last), 64'd0);
        fifo_q.delete();
        reset_base     = push_log.size();
        n_pushed       = 0;
        n_popped       = 0;
        bus.fifo_empty = 1'b1;
        bus.m_ready    = 1'b0;
    endtask

    task automatic release_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        bus.m_ready = 1'b1;
        while (exp_idx < push_log.size() && n < limit) begin
            tick();
            n++;
        end
        check("drain_complete", 64'(push_log.size() - exp_idx), 64'd0);
    endtask

    initial begin
        int base;
        rst              = 1'b1;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
        bus.m_ready      = 1'b0;

        // Reset with words waiting upstream: nothing moves until release.
        assert_reset();
        for (int i = 0; i < 3; i++) push(DW'(32'h100 + i));
        #1;
        check("rst_hold_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        tick();
        check("rst_hold_valid", 64'(bus.m_valid), 64'd0);
        release_reset();
        drain(50);
        check("t1_beats", 64'(n_accepted), 64'd3);

        // Latency and full-rate burst of eight beats.
        assert_reset();
        release_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(DW'(i));
        #1;
        check("lat_rd_en_c0", 64'(bus.fifo_rd_en), 64'd1);
        check("lat_valid_c0", 64'(bus.m_valid), 64'd0);
        tick();
        check("lat_valid_c1", 64'(bus.m_valid), 64'd0);
        tick();
        check("lat_valid_c2", 64'(bus.m_valid), 64'd1);
        base = n_accepted;
        repeat (8) tick();
        check("throughput_8_in_8", 64'(n_accepted - base), 64'd8);
        check("t2_bursts", 64'(n_bursts), 64'd2);

        // Back-pressure while streaming.
        for (int i = 0; i < 8; i++) push(DW'(32'h300 + i));
        repeat (4) tick();
        bus.m_ready = 1'b0;
        repeat (3) tick();
        #1;
        check("stall_rd_en_off", 64'(bus.fifo_rd_en), 64'd0);
        check("stall_valid_on", 64'(bus.m_valid), 64'd1);
        repeat (2) tick();
        drain(50);
        check("t3_beats", 64'(n_accepted), 64'd16);

        // Fifo runs dry mid-burst, then resumes.
        assert_reset();
        release_reset();
        push(DW'(32'h400));
        push(DW'(32'h401));
        drain(50);
        repeat (3) tick();
        check("gap_valid_low", 64'(bus.m_valid), 64'd0);
        check("gap_bursts", 64'(n_bursts), 64'd0);
        push(DW'(32'h402));
        push(DW'(32'h403));
        drain(50);
        check("t4_bursts", 64'(n_bursts), 64'd1);

        // Reset with data buffered; the next data starts a fresh burst.
        assert_reset();
        release_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(DW'(32'h500 + i));
        repeat (4) tick();
        bus.m_ready = 1'b0;
        tick();
        check("pre_rst_valid", 64'(bus.m_valid), 64'd1);
        check("pre_rst_beats", 64'(n_accepted), 64'd2);
        assert_reset();
        release_reset();
        for (int i = 0; i < 5; i++) push(DW'(32'h5A0 + i));
        drain(50);
        check("t5_bursts", 64'(n_bursts), 64'd1);

        // Ten beats: two complete bursts.
        assert_reset();
        release_reset();
        for (int i = 0; i < 10; i++) push(DW'(32'h600 + i));
        drain(60);
        check("t6_beats", 64'(n_accepted), 64'd10);
`ifdef FIFO_BURST_READER_STATS_EN
        check("stat_beats_10", 64'(stat_beats), 64'd10);
        check("stat_bursts_2", 64'(stat_bursts), 64'd2);
`endif

        // Random traffic and random back-pressure.
        assert_reset();
        release_reset();
        for (int c = 0; c < 600; c++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) push($urandom);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(100);
        check("rand_all_delivered", 64'(n_accepted), 64'(n_pushed));
        check("rand_bursts", 64'(n_bursts), 64'(n_pushed / BL));
`ifdef FIFO_BURST_READER_STATS_EN
        check("rand_stat_beats", 64'(stat_beats), 64'(n_pushed));
        check("rand_stat_bursts", 64'(stat_bursts), 64'(n_pushed / BL));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
